// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - load size encodings and lane widths shared by the MEM/WB stage and data_mem
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b11
  } bhw_e;

  localparam int BYTE_SZ     = 8;
  localparam int HALFWORD_SZ = 16;
  localparam int WORD_SZ     = 32;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM-side inputs and WB-side outputs of the MEM/WB boundary
interface mem_wb_stage_if #(
  parameter int B = 32,
  parameter int R = 5,
  parameter int C = 32
);
  logic         i_enable;
  logic         i_flush;
  logic         i_valid;
  logic         i_reg_write;
  logic         i_mem_to_reg;
  logic [1:0]   i_bhw;
  logic         i_unsigned;
  logic [1:0]   i_addr_lsb;
  logic [B-1:0] i_mem_data;
  logic [B-1:0] i_alu_result;
  logic [R-1:0] i_write_reg;

  logic         o_reg_write;
  logic [R-1:0] o_write_reg;
  logic [B-1:0] o_wb_data;
  logic [B-1:0] o_load_data;
  logic         o_misaligned;
  logic         o_valid;
  logic [C-1:0] o_retired_count;

  modport master (
    output i_enable, i_flush, i_valid, i_reg_write, i_mem_to_reg, i_bhw,
           i_unsigned, i_addr_lsb, i_mem_data, i_alu_result, i_write_reg,
    input  o_reg_write, o_write_reg, o_wb_data, o_load_data, o_misaligned,
           o_valid, o_retired_count
  );

  modport slave (
    input  i_enable, i_flush, i_valid, i_reg_write, i_mem_to_reg, i_bhw,
           i_unsigned, i_addr_lsb, i_mem_data, i_alu_result, i_write_reg,
    output o_reg_write, o_write_reg, o_wb_data, o_load_data, o_misaligned,
           o_valid, o_retired_count
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - little-endian byte/halfword lane select and extension for loads
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [WORD_SZ-1:0] i_data,
  input  logic [1:0]         i_bhw,
  input  logic               i_unsigned,
  input  logic [1:0]         i_addr_lsb,
  output logic [WORD_SZ-1:0] o_data,
  output logic               o_misaligned
);
  logic [BYTE_SZ-1:0]     byte_lane;
  logic [HALFWORD_SZ-1:0] half_lane;

  // Halfword lane uses only addr bit 1, so a misaligned halfword still shows a defined value.
  assign byte_lane = i_data[{i_addr_lsb, 3'b000} +: BYTE_SZ];
  assign half_lane = i_addr_lsb[1] ? i_data[31:16] : i_data[15:0];

  always_comb begin
    o_data       = i_data;
    o_misaligned = 1'b0;
    case (i_bhw)
      BYTE: begin
        o_data = {{(WORD_SZ-BYTE_SZ){byte_lane[BYTE_SZ-1] & ~i_unsigned}}, byte_lane};
      end
      HALFWORD: begin
        o_data       = {{(WORD_SZ-HALFWORD_SZ){half_lane[HALFWORD_SZ-1] & ~i_unsigned}}, half_lane};
        o_misaligned = i_addr_lsb[0];
      end
      default: begin
        o_misaligned = (i_addr_lsb != 2'b00);
      end
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load alignment, write-back qualification and retire counter
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int B = 32,
  parameter int R = 5,
  parameter int C = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mem_wb_stage_if.slave bus
);
  localparam logic [R-1:0] ZERO_REG = '0;

  logic [B-1:0] load_value;
  logic         lane_misaligned;
  logic         misaligned_load;
  logic [C-1:0] count_q;

  load_align u_load_align (
    .i_data       (bus.i_mem_data),
    .i_bhw        (bus.i_bhw),
    .i_unsigned   (bus.i_unsigned),
    .i_addr_lsb   (bus.i_addr_lsb),
    .o_data       (load_value),
    .o_misaligned (lane_misaligned)
  );

  // Only real loads can fault; an ALU op with odd low address bits is not an access.
  assign misaligned_load = bus.i_valid & bus.i_mem_to_reg & lane_misaligned;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_reg_write  <= 1'b0;
      bus.o_write_reg  <= '0;
      bus.o_wb_data    <= '0;
      bus.o_load_data  <= '0;
      bus.o_misaligned <= 1'b0;
      bus.o_valid      <= 1'b0;
      count_q          <= '0;
    end else if (bus.i_flush) begin
      bus.o_reg_write  <= 1'b0;
      bus.o_write_reg  <= '0;
      bus.o_wb_data    <= '0;
      bus.o_load_data  <= '0;
      bus.o_misaligned <= 1'b0;
      bus.o_valid      <= 1'b0;
    end else if (bus.i_enable) begin
      bus.o_reg_write  <= bus.i_valid & bus.i_reg_write & ~misaligned_load &
                          (bus.i_write_reg != ZERO_REG);
      bus.o_write_reg  <= bus.i_write_reg;
      bus.o_wb_data    <= bus.i_mem_to_reg ? load_value : bus.i_alu_result;
      bus.o_load_data  <= load_value;
      bus.o_misaligned <= misaligned_load;
      bus.o_valid      <= bus.i_valid;
      if (bus.i_valid) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.o_retired_count = count_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed and randomized self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  localparam int B = 32;
  localparam int R = 5;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.B(B), .R(R), .C(C)) bus ();

  mem_wb_stage #(.B(B), .R(R), .C(C)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Expected output state of the stage
  logic         e_reg_write, e_mis, e_valid;
  logic [R-1:0] e_write_reg;
  logic [B-1:0] e_wb, e_load;
  logic [C-1:0] e_cnt;

  function automatic logic [31:0] ref_load(logic [31:0] d, logic [1:0] bhw, logic uns, logic [1:0] lsb);
    logic [31:0] v;
    if (bhw == 2'b00) begin
      v = (d >> (32'(lsb) * 8)) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (bhw == 2'b01) begin
      v = (d >> (32'(lsb[1]) * 16)) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic ref_mis(logic [1:0] bhw, logic [1:0] lsb);
    if (bhw == 2'b01) return (lsb % 2) == 1;
    if (bhw == 2'b00) return 1'b0;
    return lsb != 2'b00;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_reg_write = 0; e_mis = 0; e_valid = 0;
    e_write_reg = '0; e_wb = '0; e_load = '0; e_cnt = '0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".reg_write"}, 32'(bus.o_reg_write), 32'(e_reg_write));
    chk({tag, ".write_reg"}, 32'(bus.o_write_reg), 32'(e_write_reg));
    chk({tag, ".wb_data"}, bus.o_wb_data, e_wb);
    chk({tag, ".load_data"}, bus.o_load_data, e_load);
    chk({tag, ".misaligned"}, 32'(bus.o_misaligned), 32'(e_mis));
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(e_valid));
    chk({tag, ".count"}, 32'(bus.o_retired_count), 32'(e_cnt));
  endtask

  task automatic drive(logic v, logic rw, logic m2r, logic [1:0] bhw, logic uns, logic [1:0] lsb,
                       logic [31:0] data, logic [31:0] alu, logic [R-1:0] wr);
    bus.i_valid = v; bus.i_reg_write = rw; bus.i_mem_to_reg = m2r; bus.i_bhw = bhw;
    bus.i_unsigned = uns; bus.i_addr_lsb = lsb; bus.i_mem_data = data;
    bus.i_alu_result = alu; bus.i_write_reg = wr;
  endtask

  task automatic drive_random();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
          $urandom, $urandom, ($urandom_range(0, 3) == 0) ? '0 : R'($urandom));
  endtask

  // One clock: predict from the current inputs, take the edge, compare.
  task automatic cycle(string tag);
    logic [31:0] ld;
    logic        mis_ld;
    ld     = ref_load(bus.i_mem_data, bus.i_bhw, bus.i_unsigned, bus.i_addr_lsb);
    mis_ld = bus.i_valid && bus.i_mem_to_reg && ref_mis(bus.i_bhw, bus.i_addr_lsb);
    if (bus.i_flush) begin
      e_reg_write = 0; e_mis = 0; e_valid = 0; e_write_reg = '0; e_wb = '0; e_load = '0;
    end else if (bus.i_enable) begin
      e_reg_write = bus.i_valid && bus.i_reg_write && !mis_ld && (bus.i_write_reg != 0);
      e_write_reg = bus.i_write_reg;
      e_wb        = bus.i_mem_to_reg ? ld : bus.i_alu_result;
      e_load      = ld;
      e_mis       = mis_ld;
      e_valid     = bus.i_valid;
      if (bus.i_valid) e_cnt = C'((int'(e_cnt) + 1) % (1 << C));
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.i_enable = 1'b1;
    bus.i_flush  = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 2'b00, '0, '0, '0);
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("idle_after_reset");

    drive(1, 1, 1, 2'b00, 0, 2'b11, 32'h80FF_7F01, 32'h0, 5);
    cycle("lb_signed");
    chk("lb_signed.lit", bus.o_wb_data, 32'hFFFF_FF80);
    chk("lb_signed.wr_lit", 32'(bus.o_write_reg), 32'd5);
    drive(1, 1, 1, 2'b00, 1, 2'b11, 32'h80FF_7F01, 32'h0, 5);
    cycle("lbu");
    chk("lbu.lit", bus.o_wb_data, 32'h0000_0080);
    drive(1, 1, 1, 2'b01, 0, 2'b10, 32'h8001_7FFE, 32'h0, 5);
    cycle("lh_hi");
    chk("lh_hi.lit", bus.o_wb_data, 32'hFFFF_8001);
    drive(1, 1, 1, 2'b01, 1, 2'b00, 32'h8001_7FFE, 32'h0, 5);
    cycle("lhu_lo");
    chk("lhu_lo.lit", bus.o_wb_data, 32'h0000_7FFE);
    drive(1, 1, 1, 2'b01, 0, 2'b01, 32'h8001_7FFE, 32'h0, 5);
    cycle("lh_mis");
    chk("lh_mis.flag_lit", 32'(bus.o_misaligned), 32'd1);
    chk("lh_mis.count_lit", 32'(bus.o_retired_count), 32'd5);
    drive(1, 1, 1, 2'b11, 0, 2'b10, 32'h1234_5678, 32'h0, 7);
    cycle("lw_mis");
    drive(1, 1, 0, 2'b11, 0, 2'b01, 32'h0, 32'hDEAD_BEEF, 0);
    cycle("alu_zero");
    chk("alu_zero.lit", bus.o_wb_data, 32'hDEAD_BEEF);
    drive(1, 1, 0, 2'b10, 0, 2'b11, 32'h0, 32'hCAFE_0001, 9);
    cycle("alu_odd_addr");

    drive(1, 1, 1, 2'b11, 0, 2'b00, 32'hA5A5_0F0F, 32'h0, 12);
    cycle("stall_capture");
    bus.i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      cycle("stall_hold");
    end
    chk("stall.lit", bus.o_wb_data, 32'hA5A5_0F0F);
    bus.i_flush = 1'b1;
    cycle("flush_over_stall");
    bus.i_flush  = 1'b0;
    bus.i_enable = 1'b1;

    for (int i = 0; i < 300; i++) begin
      drive_random();
      bus.i_enable = ($urandom_range(0, 4) != 0);
      bus.i_flush  = ($urandom_range(0, 9) == 0);
      cycle("random");
    end
    bus.i_enable = 1'b1;
    bus.i_flush  = 1'b0;

    // Build up count=7 with a live write, then reset between edges.
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_again");
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 0, 2'b11, 0, 2'b00, 32'h0, 32'(i), 3);
      cycle("count_up");
    end
    chk("pre_async.count_lit", 32'(bus.o_retired_count), 32'd7);
    chk("pre_async.rw_lit", 32'(bus.o_reg_write), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #2;
    rst = 1'b0;
    drive(0, 1, 1, 2'b00, 0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    cycle("post_reset_bubble");

    for (int i = 0; i < 16; i++) begin
      drive_random();
      bus.i_valid = 1'b1;
      cycle("wrap");
    end
    chk("wrap.count_lit", 32'(bus.o_retired_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Sits directly downstream of the data memory. It is the MEM/WB pipeline boundary of the 5-stage core.
- It takes the raw 32-bit word the memory reads at a word address, extracts and extends the byte or halfword lane selected by the load size and address LSBs, then registers it together with the WB control and the ALU result.
- It drives the register-file write port and keeps a retired-instruction counter for the debugger.

Parameters:
- B, 32, data width in bits. Must be 32: lane logic assumes 4 bytes per word.
- R, 5, register-file address width.
- C, 32, retired-instruction counter width.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  stage advance; 0 = stall (hold all registers)
- i_flush  in  1  insert bubble
- i_valid  in  1  MEM stage holds a real instruction (0 = bubble)
- i_reg_write  in  1  instruction writes the register file
- i_mem_to_reg  in  1  write-back source: 1 = load data, 0 = ALU result
- i_bhw  in  2  load size: 00 byte, 01 halfword, 11 word, 10 treated as word
- i_unsigned  in  1  1 = zero-extend (LBU/LHU), 0 = sign-extend
- i_addr_lsb  in  2  byte address bits [1:0] of the access
- i_mem_data  in  B  raw word read from data memory
- i_alu_result  in  B  ALU result / address from EX/MEM
- i_write_reg  in  R  destination register
- o_reg_write  out  1  registered write enable, already qualified
- o_write_reg  out  R  registered destination
- o_wb_data  out  B  registered write-back value
- o_load_data  out  B  registered aligned/extended load value (debug)
- o_misaligned  out  1  registered misaligned-load flag
- o_valid  out  1  registered valid
- o_retired_count  out  C  count of retired valid instructions

Behaviour:
- Reset (asynchronous): every output register goes to 0, including o_retired_count. An in-flight instruction is discarded. No write-back occurs on the first edge after reset deassertion unless new inputs are captured.
- Latency: 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N.
- Priority per edge: reset > flush > stall > capture.
  - Flush: o_valid, o_reg_write and o_misaligned are cleared. The data registers may hold any value, but are cleared to 0 for deterministic checking.
  - i_enable=0 with i_flush=0: all registers hold, and the counter holds.
  - i_flush=1 and i_enable=0 together: flush wins.
- Lane extraction is combinational, before the register. Memory is little-endian: byte n = i_mem_data[8n+7:8n].
  - Byte load: lane = i_addr_lsb. Extend bit 7 (signed) or pad with 0 (unsigned).
  - Halfword load: i_addr_lsb[1] selects [15:0] (0) or [31:16] (1). Extend bit 15 or pad with 0.
  - Word load: pass through; i_unsigned is ignored.
- Misalignment: halfword with i_addr_lsb[0]=1, or word with i_addr_lsb≠00.
  - o_misaligned = i_valid & i_mem_to_reg & misaligned.
  - When set, o_reg_write is forced to 0. o_load_data and o_wb_data still show the extraction, computed with i_addr_lsb[0] ignored.
  - Misalignment on non-load instructions (i_mem_to_reg=0) is not flagged.
- Write-back qualification:
  - o_reg_write = i_valid & i_reg_write & ~misaligned-load & (i_write_reg≠0).
  - Writes to $zero are suppressed.
- o_wb_data = i_mem_to_reg ? extracted load value : i_alu_result.
- Counter: increments by 1 on each capture edge with i_valid=1 and no flush, including misaligned loads. It wraps from 2^C−1 to 0 silently.

Decomposition:
- Shared package (also used by data_mem):
  - BHW encodings BYTE=2'b00, HALFWORD=2'b01, WORD=2'b11
  - BYTE_SZ=8, HALFWORD_SZ=16
- One natural sub-module: load_align, which is purely combinational. Inputs: raw word, bhw, unsigned, addr_lsb. Outputs: extended data and misaligned flag. It is reusable by any future load/store unit.

Test Plan:
- Signed byte load, reg_write=1, mem_to_reg=1, valid=1, write_reg=5:
  - mem_data=32'h80FF_7F01, bhw=00, unsigned=0, lsb=11 → next cycle o_wb_data=32'hFFFF_FF80, o_reg_write=1, o_write_reg=5.
  - Same stimulus with unsigned=1 → o_wb_data=32'h0000_0080.
- Halfword loads on mem_data=32'h8001_7FFE:
  - lsb=10, signed → o_wb_data=32'hFFFF_8001.
  - lsb=00, unsigned → o_wb_data=32'h0000_7FFE.
  - lsb=01 → o_misaligned=1, o_reg_write=0, o_retired_count still +1.
- ALU path: mem_to_reg=0, alu_result=32'hDEAD_BEEF, write_reg=0 → o_wb_data=32'hDEAD_BEEF, o_reg_write=0 ($zero suppressed).
- Stall/flush:
  - Capture a load, then hold i_enable=0 for 3 cycles with changing inputs → outputs and counter frozen.
  - Assert i_flush with i_enable=0 → o_valid=0, o_reg_write=0.
- Reset mid-operation: assert i_reset asynchronously between edges while o_reg_write=1 and count=7 → all outputs 0 immediately, without waiting for a clock edge. Counter wrap check with C=4: 16 valid captures from 0 → count returns to 0.
